// File: rtl/cdb_request_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cdb_request_buffer                                           |
// | Description : Per-unit result FIFO that requests the CDB, and on a grant   |
// |               broadcasts the head entry.                                   |
// |               Optional macro CDB_BYPASS_EN: same-cycle empty-buffer bypass. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module cdb_request_buffer #(
   parameter int XLEN      = 32,
   parameter int TAG_WIDTH = 5,
   parameter int DEPTH     = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [XLEN-1:0]        in_value,
   input  logic [TAG_WIDTH-1:0]   in_tag,
   input  logic                   flush,
   output logic                   cdb_request,
   input  logic                   cdb_grant,
   output logic [XLEN-1:0]        cdb_value,
   output logic [TAG_WIDTH-1:0]   cdb_tag,
   output logic                   cdb_valid,
   output logic [$clog2(DEPTH):0] count
);

   localparam int             PW     = $clog2(DEPTH);
   localparam logic [PW:0]    c_FULL = (PW+1)'(DEPTH);
   localparam logic [PW-1:0]  c_ONE  = PW'(1);

   logic [XLEN-1:0]      r_val [DEPTH];
   logic [TAG_WIDTH-1:0] r_tag [DEPTH];
   logic [PW-1:0]        r_head;
   logic [PW-1:0]        r_tail;
   logic [PW:0]          r_count;

   logic                 w_empty;
   logic                 w_full;
   logic                 w_req;
   logic                 w_byp;
   logic                 w_pop;
   logic                 w_push;
   logic [XLEN-1:0]      w_val;
   logic [TAG_WIDTH-1:0] w_tag;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == c_FULL);

`ifdef CDB_BYPASS_EN
   // An empty buffer may forward the incoming result straight onto the bus.
   assign w_req = (!w_empty || in_valid) && !flush;
   assign w_byp = w_empty && w_req && cdb_grant;
   assign w_val = w_empty ? in_value : r_val[r_head];
   assign w_tag = w_empty ? in_tag   : r_tag[r_head];
`else
   assign w_req = !w_empty && !flush;
   assign w_byp = 1'b0;
   assign w_val = r_val[r_head];
   assign w_tag = r_tag[r_head];
`endif

   assign w_pop  = w_req && cdb_grant && !w_empty;
   assign w_push = in_valid && !w_full && !flush && !w_byp;

   assign in_ready    = !w_full;
   assign cdb_request = w_req;
   assign cdb_valid   = w_pop || w_byp;
   // Gated to zero so the arbiter can OR-merge all units' buses.
   assign cdb_value   = w_val & {XLEN{cdb_valid}};
   assign cdb_tag     = w_tag & {TAG_WIDTH{cdb_valid}};
   assign count       = r_count;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_val[r_tail] <= in_value;
         r_tag[r_tail] <= in_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + c_ONE;
         if (w_pop)  r_head <= r_head + c_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cdb_request_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cdb_request_buffer                                        |
// | Description : Directed plus random stimulus against a queue-based model.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_cdb_request_buffer;

   localparam int XLEN  = 32;
   localparam int TW    = 5;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_value;
   logic [TW-1:0]   in_tag;
   logic            flush;
   logic            cdb_request;
   logic            cdb_grant;
   logic [XLEN-1:0] cdb_value;
   logic [TW-1:0]   cdb_tag;
   logic            cdb_valid;
   logic [2:0]      count;

   cdb_request_buffer #(.XLEN(XLEN), .TAG_WIDTH(TW), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_value(in_value), .in_tag(in_tag), .flush(flush),
      .cdb_request(cdb_request), .cdb_grant(cdb_grant), .cdb_value(cdb_value),
      .cdb_tag(cdb_tag), .cdb_valid(cdb_valid), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [XLEN-1:0] v;
      logic [TW-1:0]   t;
   } ent_t;

   ent_t q[$];
   int   n_pass  = 0;
   int   n_total = 0;
   int   cyc     = 0;
   logic [TW-1:0] emitted[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
   endtask

   // One clock cycle: drive inputs, check outputs against the model, advance model.
   task automatic step(input logic rn, input logic iv, input logic [XLEN-1:0] v,
                       input logic [TW-1:0] t, input logic fl, input logic gr);
      logic            e_req, e_valid, from_q;
      logic [XLEN-1:0] e_val;
      logic [TW-1:0]   e_tag;
      int              n;
      @(negedge clk);
      reset_n = rn; in_valid = iv; in_value = v; in_tag = t; flush = fl; cdb_grant = gr;
      #1;
      n = q.size();
      from_q = (n != 0);
`ifdef CDB_BYPASS_EN
      e_req = !fl && (from_q || iv);
`else
      e_req = !fl && from_q;
`endif
      e_valid = e_req && gr;
      e_val = '0;
      e_tag = '0;
      if (e_valid) begin
         e_val = from_q ? q[0].v : v;
         e_tag = from_q ? q[0].t : t;
      end
      if (rn) begin
         chk("count",       32'(count),       32'(n));
         chk("in_ready",    32'(in_ready),    32'(n < DEPTH));
         chk("cdb_request", 32'(cdb_request), 32'(e_req));
         chk("cdb_valid",   32'(cdb_valid),   32'(e_valid));
         chk("cdb_value",   cdb_value,        e_val);
         chk("cdb_tag",     32'(cdb_tag),     32'(e_tag));
         if (cdb_valid) emitted.push_back(cdb_tag);
      end
      @(posedge clk);
      cyc++;
      if (!rn || fl) begin
         q.delete();
      end else begin
         if (e_valid && from_q) void'(q.pop_front());
         if (iv && n < DEPTH && !(e_valid && !from_q)) q.push_back('{v: v, t: t});
      end
   endtask

   task automatic expect_emitted(input string tag, input logic [TW-1:0] exp_t[$]);
      chk({tag, "_len"}, 32'(emitted.size()), 32'(exp_t.size()));
      for (int i = 0; i < exp_t.size() && i < emitted.size(); i++)
         chk(tag, 32'(emitted[i]), 32'(exp_t[i]));
      emitted.delete();
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; in_value = '0; in_tag = '0; flush = 1'b0; cdb_grant = 1'b0;

      // Reset held with a pending input
      step(0, 1, 32'h1111_1111, 5'd9, 0, 0);
      step(0, 1, 32'h1111_1111, 5'd9, 0, 0);
      step(1, 0, '0, '0, 0, 0);
      emitted.delete();

      // Single result, delayed grant
      step(1, 1, 32'hDEAD_BEEF, 5'd3, 0, 0);
      step(1, 0, '0, '0, 0, 0);
      step(1, 0, '0, '0, 0, 0);
      step(1, 0, '0, '0, 0, 1);
      step(1, 0, '0, '0, 0, 0);
      expect_emitted("single", '{5'd3});

      // Fill, attempted overflow push, then drain in order
      for (int i = 1; i <= 4; i++) step(1, 1, 32'(i * 16'h1001), 5'(i), 0, 0);
      step(1, 1, 32'hBAD0_0000, 5'd30, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 0, '0, '0, 0, 1);
      step(1, 0, '0, '0, 0, 0);
      expect_emitted("fill_order", '{5'd1, 5'd2, 5'd3, 5'd4});

      // Steady-state push+pop across the pointer wrap
      step(1, 1, 32'hA0, 5'd10, 0, 0);
      step(1, 1, 32'hA1, 5'd11, 0, 0);
      for (int i = 0; i < 6; i++) step(1, 1, 32'hB0 + 32'(i), 5'(12 + i), 0, 1);
      step(1, 0, '0, '0, 0, 1);
      step(1, 0, '0, '0, 0, 1);
      step(1, 0, '0, '0, 0, 1);
      expect_emitted("wrap", '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17});

      // Flush with simultaneous push and grant
      for (int i = 0; i < 3; i++) step(1, 1, 32'hC0 + 32'(i), 5'(20 + i), 0, 0);
      step(1, 1, 32'hCC, 5'd25, 1, 1);
      step(1, 0, '0, '0, 0, 1);
      step(1, 0, '0, '0, 0, 1);
`ifdef CDB_BYPASS_EN
      expect_emitted("flush", '{});
      // Bypass into an empty buffer
      step(1, 1, 32'h7777, 5'd7, 0, 1);
      step(1, 0, '0, '0, 0, 0);
      expect_emitted("bypass", '{5'd7});
`else
      expect_emitted("flush", '{});
`endif

      // Randomized traffic including occasional flush and reset
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 63) != 0), $urandom_range(0, 1), $urandom, 5'($urandom),
              ($urandom_range(0, 23) == 0), $urandom_range(0, 1));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cdb_request_buffer.md
Name: cdb_request_buffer

Overview:
- Requester-side endpoint of the common data bus (CDB) arbitration handshake, one instance per functional unit.
- Queues completed results (value + ROB tag) in a small FIFO and raises cdb_request while any are pending.
- On cdb_grant, drives the head entry onto the CDB for one cycle and pops it.
- cdb_request feeds one bit of the arbiter's request vector; cdb_grant is the matching bit of its one-hot grant vector.

Parameters:
- XLEN, 32, result value width.
- TAG_WIDTH, 5, ROB tag width.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  functional unit presents a result this cycle.
- in_ready  output  1  buffer accepts a result this cycle.
- in_value  input  XLEN  result value.
- in_tag  input  TAG_WIDTH  destination ROB tag.
- flush  input  1  synchronous clear of all pending entries (mispredict recovery).
- cdb_request  output  1  to the arbiter request bit.
- cdb_grant  input  1  from the arbiter grant bit.
- cdb_value  output  XLEN  broadcast value; zero when not granted.
- cdb_tag  output  TAG_WIDTH  broadcast tag; zero when not granted.
- cdb_valid  output  1  this unit is driving the CDB this cycle.
- count  output  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Clock and reset: single clock clk. reset_n is synchronous and active-low: sampled on the rising edge of clk, and reset takes effect when reset_n==0.
- Reset: head, tail and count cleared; entries are don't-care. After reset, outputs are in_ready=1, cdb_request=0, cdb_valid=0, cdb_value=0, cdb_tag=0 and count=0.
- Push: occurs when in_valid && in_ready. The entry is written at tail; tail increments mod DEPTH.
- in_ready = (count != DEPTH). There is no same-cycle pop-to-push pass-through when full.
- Request: cdb_request = (count != 0) && !flush. This output is combinational from registered state and flush only; it has no path from cdb_grant.
- Pop: occurs when cdb_request && cdb_grant.
  - cdb_valid=1 and cdb_value/cdb_tag = head entry in the same cycle (zero-latency drive).
  - head increments mod DEPTH at the clock edge.
- Output gating: cdb_value/cdb_tag are AND-gated by cdb_valid so that the arbiter side can OR-merge units.
- Spurious grant: cdb_grant while cdb_request=0 is ignored. cdb_valid=0, and state is unchanged.
- Simultaneous push and pop: count unchanged, head and tail both advance. This applies at any occupancy below DEPTH.
- Wrap-around: pointers wrap at DEPTH. FIFO order is preserved across the wrap.
- Latency: minimum result-to-CDB latency is 1 cycle (push at edge N, request visible in cycle N+1).
- Flush:
  - Highest priority; overrides a same-cycle push and grant.
  - Forces cdb_request=0 and cdb_valid=0 in that cycle.
  - Next state is empty.
- Reset mid-operation: reset overrides flush, push and grant. All pending entries are dropped.
- count = pushes − pops; it never exceeds DEPTH and never underflows.

Optional Feature:
- Macro CDB_BYPASS_EN.
- Defined:
  - When count==0 and in_valid && !flush, cdb_request=1 in the same cycle.
  - If granted, in_value/in_tag drive the CDB directly with cdb_valid=1, and the entry is not written.
  - If not granted, the input is pushed normally.
  - This adds a combinational in_valid→cdb_request path.
- Undefined: behaviour exactly as above; minimum latency is 1 cycle.

Test Plan:
- Reset: hold reset_n=0 with in_valid=1, then release → count=0, cdb_request=0, in_ready=1, cdb_value=0.
- Single result: push value 0xDEADBEEF with tag 3, cdb_grant=0 for 2 cycles, then grant → cdb_request=1 from the cycle after the push. In the grant cycle cdb_valid=1, value 0xDEADBEEF, tag 3; next cycle count=0 and cdb_request=0.
- Fill and order: push tags 1,2,3,4 with no grant → in_ready=0 and count=4. Grant for 4 consecutive cycles → tags broadcast 1,2,3,4, then cdb_request=0.
- Wrap and simultaneous ops: with count=2, push and grant together for 6 cycles → count stays 2, tags emitted in push order across the pointer wrap. Grant with count=0 → cdb_valid=0 and cdb_value=0.
- Flush: count=3, assert flush together with in_valid and cdb_grant → cdb_valid=0 that cycle, count=0 next cycle, no later broadcast of the flushed tags.
- Bypass (CDB_BYPASS_EN defined): empty buffer, in_valid with tag 7 and cdb_grant=1 in the same cycle → cdb_valid=1 and tag 7 that cycle, count remains 0.
